// File: rtl/exu_bp_update_q_if.sv
// rtl/exu_bp_update_q_if.sv - resolved-branch update and BHT write-port bundle
interface exu_bp_update_q_if #(
    parameter int IDX_W = 8
);
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_index;
    logic             upd_way;
    logic [1:0]       upd_hist;
    logic             upd_ataken;
    logic             upd_misp;

    logic             bht_wr_req;
    logic             bht_wr_gnt;
    logic [IDX_W-1:0] bht_wr_index;
    logic             bht_wr_way;
    logic [1:0]       bht_wr_hist;
    logic             bht_wr_urgent;

    // master is the EX resolver plus the IFU arbiter; slave is the queue
    modport master (
        output upd_valid, upd_index, upd_way, upd_hist, upd_ataken, upd_misp, bht_wr_gnt,
        input  upd_ready, bht_wr_req, bht_wr_index, bht_wr_way, bht_wr_hist, bht_wr_urgent
    );

    modport slave (
        input  upd_valid, upd_index, upd_way, upd_hist, upd_ataken, upd_misp, bht_wr_gnt,
        output upd_ready, bht_wr_req, bht_wr_index, bht_wr_way, bht_wr_hist, bht_wr_urgent
    );
endinterface

// File: rtl/exu_bp_update_q.sv
// rtl/exu_bp_update_q.sv - resolved-branch BHT update FIFO with starvation escalation
// Optional tail coalescing of same {index, way} updates: EXU_BP_UPD_COALESCE_EN.
module exu_bp_update_q #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_l,
    exu_bp_update_q_if.slave         bp,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              misp_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             way;
        logic [1:0]       hist;
        logic             ataken;
        logic             misp;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_URGENT
    } stv_state_e;

    entry_t             mem_q [DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [15:0]        misp_cnt_q, misp_cnt_d;
    stv_state_e         state_q, state_d;
    logic [2:0]         stv_cnt_q, stv_cnt_d;

    logic               push_acc;
    logic               pop;
    logic               merge;
    logic               alloc;
    logic [PTR_W:0]     occ_next;
    entry_t             head;
    entry_t             new_ent;
    entry_t             mem_wdata;
    logic [PTR_W-1:0]   mem_waddr;
    logic               mem_we;
    logic               unused_head;

    assign occupancy     = wr_ptr_q - rd_ptr_q;
    assign bp.upd_ready  = (occupancy != FULL_OCC);
    assign bp.bht_wr_req = (occupancy != '0);

    assign head = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Storage is never reset, so gate head fields to keep them zero while empty.
    assign bp.bht_wr_index  = bp.bht_wr_req ? head.index : '0;
    assign bp.bht_wr_way    = bp.bht_wr_req ? head.way   : 1'b0;
    assign bp.bht_wr_hist   = bp.bht_wr_req ? head.hist  : 2'b00;
    assign bp.bht_wr_urgent = (state_q == ST_URGENT);
    assign unused_head      = ^{head.ataken, head.misp};

    assign push_acc = bp.upd_valid & bp.upd_ready;
    assign pop      = bp.bht_wr_req & bp.bht_wr_gnt;

    assign new_ent = '{
        index:  bp.upd_index,
        way:    bp.upd_way,
        hist:   bp.upd_hist,
        ataken: bp.upd_ataken,
        misp:   bp.upd_misp
    };

`ifdef EXU_BP_UPD_COALESCE_EN
    logic [PTR_W-1:0] tail_addr;
    entry_t           tail;

    assign tail_addr = wr_ptr_q[PTR_W-1:0] - PTR_W'(1);
    assign tail      = mem_q[tail_addr];
    // A lone entry leaving this cycle cannot absorb the update; it is pushed fresh.
    assign merge = push_acc & bp.bht_wr_req
                 & (tail.index == bp.upd_index) & (tail.way == bp.upd_way)
                 & ~(pop & (occupancy == (PTR_W+1)'(1)));
`else
    assign merge = 1'b0;
`endif

    assign alloc = push_acc & ~merge;

    always_comb begin
        mem_we    = alloc;
        mem_waddr = wr_ptr_q[PTR_W-1:0];
        mem_wdata = new_ent;
`ifdef EXU_BP_UPD_COALESCE_EN
        if (merge) begin
            mem_we         = 1'b1;
            mem_waddr      = tail_addr;
            mem_wdata.misp = tail.misp | bp.upd_misp;
        end
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(alloc);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
        occ_next = occupancy + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);
    end

    always_comb begin
        misp_cnt_d = misp_cnt_q;
        if (push_acc && bp.upd_misp && (misp_cnt_q != 16'hFFFF)) begin
            misp_cnt_d = misp_cnt_q + 16'd1;
        end
    end

    assign misp_cnt = misp_cnt_q;

    // stv_cnt holds the number of consecutive ungranted request cycles so far.
    always_comb begin
        state_d   = state_q;
        stv_cnt_d = stv_cnt_q;
        if (pop) begin
            stv_cnt_d = 3'd0;
            state_d   = (occ_next == '0) ? ST_IDLE : ST_WAIT;
        end else if (bp.bht_wr_req) begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_WAIT;
                    stv_cnt_d = 3'd1;
                end
                ST_WAIT: begin
                    if (stv_cnt_q == 3'd7) begin
                        state_d = ST_URGENT;
                    end else begin
                        stv_cnt_d = stv_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_URGENT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            misp_cnt_q <= '0;
            state_q    <= ST_IDLE;
            stv_cnt_q  <= 3'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            misp_cnt_q <= misp_cnt_d;
            state_q    <= state_d;
            stv_cnt_q  <= stv_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_exu_bp_update_q.sv
// tb/tb_exu_bp_update_q.sv - scoreboard bench for exu_bp_update_q
module tb_exu_bp_update_q;
    localparam int DEPTH = 4;
    localparam int IDX_W = 8;

    typedef struct packed {
        logic [7:0] idx;
        logic       way;
        logic [1:0] hist;
        logic       ataken;
        logic       misp;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [2:0]  occupancy;
    logic [15:0] misp_cnt;

    ent_t        exp_q[$];
    int          ung;
    int          exp_misp;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    exu_bp_update_q_if #(.IDX_W(IDX_W)) bp ();

    exu_bp_update_q #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .bp        (bp),
        .occupancy (occupancy),
        .misp_cnt  (misp_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        if (obs !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] idx, input logic w, input logic [1:0] h,
                         input logic at, input logic mp, input logic g);
        @(negedge clk);
        bp.upd_valid  = v;
        bp.upd_index  = idx;
        bp.upd_way    = w;
        bp.upd_hist   = h;
        bp.upd_ataken = at;
        bp.upd_misp   = mp;
        bp.bht_wr_gnt = g;
    endtask

    // Reference queue: push on acceptance, pop on grant.
    always @(posedge clk or negedge rst_l) begin
        int   sz;
        bit   pop_e;
        bit   acc_e;
        bit   co;
        ent_t e;
        if (!rst_l) begin
            exp_q.delete();
            ung      = 0;
            exp_misp = 0;
        end else begin
            sz    = exp_q.size();
            pop_e = bp.bht_wr_gnt && (sz != 0);
            acc_e = bp.upd_valid && (sz != DEPTH);
            e     = '{idx: bp.upd_index, way: bp.upd_way, hist: bp.upd_hist,
                      ataken: bp.upd_ataken, misp: bp.upd_misp};
            co    = 1'b0;
            if (sz != 0) ung = pop_e ? 0 : ((ung < 100) ? ung + 1 : ung);
            if (acc_e && bp.upd_misp && exp_misp != 32'hFFFF) exp_misp++;
`ifdef EXU_BP_UPD_COALESCE_EN
            co = acc_e && (sz != 0) && (exp_q[sz-1].idx == e.idx) && (exp_q[sz-1].way == e.way)
                 && !(pop_e && sz == 1);
            if (co) begin
                exp_q[sz-1].hist   = e.hist;
                exp_q[sz-1].ataken = e.ataken;
                exp_q[sz-1].misp   = exp_q[sz-1].misp | e.misp;
            end
`endif
            if (pop_e) void'(exp_q.pop_front());
            if (acc_e && !co) exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_l === 1'b1) begin
            check_val("req", 32'(bp.bht_wr_req), 32'(exp_q.size() != 0));
            check_val("occ", 32'(occupancy), 32'(exp_q.size()));
            check_val("rdy", 32'(bp.upd_ready), 32'(exp_q.size() != DEPTH));
            check_val("urgent", 32'(bp.bht_wr_urgent), 32'(ung >= 8));
            check_val("misp_cnt", 32'(misp_cnt), 32'(exp_misp));
            if (exp_q.size() != 0) begin
                check_val("head_idx", 32'(bp.bht_wr_index), 32'(exp_q[0].idx));
                check_val("head_way", 32'(bp.bht_wr_way), 32'(exp_q[0].way));
                check_val("head_hist", 32'(bp.bht_wr_hist), 32'(exp_q[0].hist));
            end
        end
    end

    initial begin
        rst_l         = 1'b0;
        bp.upd_valid  = 1'b0;
        bp.upd_index  = '0;
        bp.upd_way    = 1'b0;
        bp.upd_hist   = 2'b00;
        bp.upd_ataken = 1'b0;
        bp.upd_misp   = 1'b0;
        bp.bht_wr_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req", 32'(bp.bht_wr_req), 32'd0);
        check_val("rst_urg", 32'(bp.bht_wr_urgent), 32'd0);
        check_val("rst_occ", 32'(occupancy), 32'd0);
        check_val("rst_rdy", 32'(bp.upd_ready), 32'd1);
        check_val("rst_misp", 32'(misp_cnt), 32'd0);
        check_val("rst_idx", 32'(bp.bht_wr_index), 32'd0);
        check_val("rst_way", 32'(bp.bht_wr_way), 32'd0);
        check_val("rst_hist", 32'(bp.bht_wr_hist), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;

        // single update with grant held high
        drive(1, 8'h12, 1, 2'b10, 1, 0, 1);
        drive(0, 8'h00, 0, 2'b00, 0, 0, 1);
        check_val("lat_req", 32'(bp.bht_wr_req), 32'd1);
        check_val("lat_idx", 32'(bp.bht_wr_index), 32'h12);
        check_val("lat_hist", 32'(bp.bht_wr_hist), 32'b10);
        drive(0, 8'h00, 0, 2'b00, 0, 0, 1);
        check_val("lat_occ0", 32'(occupancy), 32'd0);

        // fill to DEPTH, hold the fifth, then drain in order
        for (int i = 0; i < 4; i++) drive(1, 8'(8'h20 + i), 1'(i), 2'(i), 0, 0, 0);
        drive(1, 8'h24, 0, 2'b11, 0, 0, 0);
        check_val("full_rdy", 32'(bp.upd_ready), 32'd0);
        check_val("full_occ", 32'(occupancy), 32'd4);
        drive(1, 8'h24, 0, 2'b11, 0, 0, 0);
        check_val("held_occ", 32'(occupancy), 32'd4);
        drive(1, 8'h24, 0, 2'b11, 0, 0, 1);
        drive(1, 8'h24, 0, 2'b11, 0, 0, 1);
        check_val("pop_occ", 32'(occupancy), 32'd3);
        check_val("pop_idx", 32'(bp.bht_wr_index), 32'h21);
        for (int i = 0; i < 6; i++) drive(0, 8'h00, 0, 2'b00, 0, 0, 1);
        check_val("drain_occ", 32'(occupancy), 32'd0);

        // starvation escalation
        drive(1, 8'h33, 0, 2'b01, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            drive(0, 8'h00, 0, 2'b00, 0, 0, 0);
            check_val("urg_rise", 32'(bp.bht_wr_urgent), 32'(i >= 9));
        end
        drive(0, 8'h00, 0, 2'b00, 0, 0, 1);
        drive(0, 8'h00, 0, 2'b00, 0, 0, 0);
        check_val("urg_fall", 32'(bp.bht_wr_urgent), 32'd0);
        check_val("urg_occ", 32'(occupancy), 32'd0);

        // same {index, way} back to back
        drive(1, 8'h40, 0, 2'b01, 0, 1, 0);
        drive(1, 8'h40, 0, 2'b11, 1, 0, 0);
        drive(0, 8'h00, 0, 2'b00, 0, 0, 0);
`ifdef EXU_BP_UPD_COALESCE_EN
        check_val("co_occ", 32'(occupancy), 32'd1);
        check_val("co_hist", 32'(bp.bht_wr_hist), 32'b11);
`else
        check_val("co_occ", 32'(occupancy), 32'd2);
        check_val("co_hist", 32'(bp.bht_wr_hist), 32'b01);
`endif
        for (int i = 0; i < 3; i++) drive(0, 8'h00, 0, 2'b00, 0, 0, 1);

        // random traffic over a small index set
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 6; i++) drive(0, 8'h00, 0, 2'b00, 0, 0, 1);

        // reset with entries queued
        for (int i = 0; i < 3; i++) drive(1, 8'(8'h50 + i), 0, 2'b10, 0, 0, 0);
        drive(0, 8'h00, 0, 2'b00, 0, 0, 0);
        check_val("pre_rst_occ", 32'(occupancy), 32'd3);
        #2 rst_l = 1'b0;
        #1;
        check_val("mid_rst_req", 32'(bp.bht_wr_req), 32'd0);
        check_val("mid_rst_occ", 32'(occupancy), 32'd0);
        drive(0, 8'h00, 0, 2'b00, 0, 0, 1);
        rst_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 0, 2'b00, 0, 0, 1);
            check_val("post_rst_req", 32'(bp.bht_wr_req), 32'd0);
        end

        // mispredict counter saturation
        for (int i = 0; i < 65534; i++) drive(1, 8'(i), 0, 2'b01, 0, 1, 1);
        drive(0, 8'h00, 0, 2'b00, 0, 0, 1);
        check_val("misp_fffe", 32'(misp_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) drive(1, 8'(i), 1, 2'b10, 1, 1, 1);
        drive(0, 8'h00, 0, 2'b00, 0, 0, 1);
        drive(0, 8'h00, 0, 2'b00, 0, 0, 1);
        check_val("misp_sat", 32'(misp_cnt), 32'hFFFF);
        check_val("sat_occ", 32'(occupancy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
